// File: rtl/mini_alu_seq.sv
// rtl/mini_alu_seq.sv - program sequencer and register file for the 2-bit-op mini ALU
//
// Debounces three raw buttons, appends switch bytes to a small program memory
// and executes them one per step press or back-to-back in RUN.
//
// Ports:
//   clk, rst_n         single clock, asynchronous active-low reset
//   instr_in[7:0]      instruction byte {op, x, y, z} from the switches
//   btn_load/step/run  raw push-buttons
//   sel[1:0]           register shown on reg_val
//   reg_val[7:0]       reg[sel], combinational
//   pc[AW-1:0]         program counter
//   len[AW:0]          number of stored instructions
//   full               len == DEPTH
//   busy               state is RUN
module mini_alu_seq #(
  parameter int DEPTH           = 16,
  parameter int DEBOUNCE_CYCLES = 120000,
  localparam int AW             = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    instr_in,
  input  logic          btn_load,
  input  logic          btn_step,
  input  logic          btn_run,
  input  logic [1:0]    sel,
  output logic [7:0]    reg_val,
  output logic [AW-1:0] pc,
  output logic [AW:0]   len,
  output logic          full,
  output logic          busy
);

  localparam int         CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Button index order: 0 = load, 1 = step, 2 = run.
  logic [2:0]    raw;
  logic [2:0]    sync1_q, sync1_d;
  logic [2:0]    sync2_q, sync2_d;
  logic [2:0]    level_q, level_d;
  logic [2:0]    press_q, press_d;
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];

  assign raw = {btn_run, btn_step, btn_load};

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    level_d = level_q;
    press_d = '0;
    for (int b = 0; b < 3; b++) begin
      cnt_d[b] = cnt_q[b];
      if (sync2_q[b] == level_q[b]) begin
        cnt_d[b] = '0;
      end else if (cnt_q[b] == CNT_LAST) begin
        // This sample is the last of the required run of differing samples.
        cnt_d[b]   = '0;
        level_d[b] = sync2_q[b];
        press_d[b] = sync2_q[b];
      end else begin
        cnt_d[b] = cnt_q[b] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      press_q <= '0;
      for (int b = 0; b < 3; b++) cnt_q[b] <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      for (int b = 0; b < 3; b++) cnt_q[b] <= cnt_d[b];
    end
  end

  // Sequencer
  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   len_q, len_d;
  logic          full_q, full_d;
  logic [7:0]    regs_q [4];
  logic [7:0]    regs_d [4];
  logic [7:0]    mem [DEPTH];

  logic          mem_we;
  logic          exec;
  logic [7:0]    instr;
  logic [1:0]    op, x, y, z;
  logic [7:0]    alu_res;
  logic [AW:0]   pc_ext, pc_inc_ext, len_inc;
  logic          pc_lt_len;
  logic          run_p, step_p, load_p;

  assign load_p = press_q[0];
  assign step_p = press_q[1];
  assign run_p  = press_q[2];

  assign instr = mem[pc_q];
  assign op    = instr[7:6];
  assign x     = instr[5:4];
  assign y     = instr[3:2];
  assign z     = instr[1:0];

  assign pc_ext     = {1'b0, pc_q};
  assign pc_inc_ext = pc_ext + {{AW{1'b0}}, 1'b1};
  assign len_inc    = len_q + {{AW{1'b0}}, 1'b1};
  assign pc_lt_len  = pc_ext < len_q;

  always_comb begin
    alu_res = '0;
    case (op)
      2'b00: alu_res = {4'h0, x, y};
      2'b01: alu_res = {x, y, 4'h0};
      2'b10: alu_res = regs_q[y] + regs_q[x];
      2'b11: alu_res = regs_q[y] - regs_q[x];
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    full_d  = full_q;
    exec    = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run_p) begin
          if (pc_lt_len) state_d = S_RUN;
        end else if (step_p) begin
          if (pc_lt_len) begin
            exec = 1'b1;
            pc_d = pc_q + 1'b1;
          end else begin
            pc_d = '0;
          end
        end else if (load_p && !full_q) begin
          mem_we = 1'b1;
          len_d  = len_inc;
          full_d = (len_inc == DEPTH_W);
        end
      end
      S_RUN: begin
        if (run_p) begin
          // Abort: pc keeps the next unexecuted index.
          state_d = S_IDLE;
        end else begin
          exec = 1'b1;
          if (pc_inc_ext == len_q) begin
            state_d = S_IDLE;
            pc_d    = '0;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int r = 0; r < 4; r++) regs_d[r] = regs_q[r];
    if (exec) regs_d[z] = alu_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      full_q  <= 1'b0;
      for (int r = 0; r < 4; r++) regs_q[r] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      full_q  <= full_d;
      for (int r = 0; r < 4; r++) regs_q[r] <= regs_d[r];
    end
  end

  // Program memory is deliberately not reset; len gates what is reachable.
  always_ff @(posedge clk) begin
    if (mem_we) mem[len_q[AW-1:0]] <= instr_in;
  end

  assign reg_val = regs_q[sel];
  assign pc      = pc_q;
  assign len     = len_q;
  assign full    = full_q;
  assign busy    = (state_q == S_RUN);

endmodule

// File: tb/tb_mini_alu_seq.sv
// tb/tb_mini_alu_seq.sv - scoreboard bench for mini_alu_seq
module tb_mini_alu_seq;

  localparam int DEPTH = 16;
  localparam int DB    = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] instr_in = 8'h00;
  logic       btn_load = 1'b0;
  logic       btn_step = 1'b0;
  logic       btn_run = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [7:0] reg_val;
  logic [3:0] pc;
  logic [4:0] len;
  logic       full;
  logic       busy;

  mini_alu_seq #(.DEPTH(DEPTH), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in),
    .btn_load(btn_load), .btn_step(btn_step), .btn_run(btn_run),
    .sel(sel), .reg_val(reg_val), .pc(pc), .len(len),
    .full(full), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int busy_cnt = 0;

  always @(negedge clk) if (busy) busy_cnt <= busy_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model
  logic [7:0] m_reg [4];
  logic [7:0] m_mem [DEPTH];
  int         m_pc;
  int         m_len;

  typedef struct packed {
    logic [31:0] regs;
    logic [7:0]  pcv;
    logic [7:0]  lenv;
  } snap_t;

  snap_t sb_q[$];

  task automatic m_reset();
    for (int r = 0; r < 4; r++) m_reg[r] = 8'h00;
    m_pc  = 0;
    m_len = 0;
  endtask

  task automatic m_exec(input logic [7:0] ins);
    logic [1:0] x, y, z;
    logic [7:0] res;
    x = ins[5:4];
    y = ins[3:2];
    z = ins[1:0];
    case (ins[7:6])
      2'd0:    res = {4'h0, x, y};
      2'd1:    res = {x, y, 4'h0};
      2'd2:    res = m_reg[y] + m_reg[x];
      default: res = m_reg[y] - m_reg[x];
    endcase
    m_reg[z] = res;
  endtask

  task automatic push_snap();
    snap_t s;
    s.regs = {m_reg[3], m_reg[2], m_reg[1], m_reg[0]};
    s.pcv  = 8'(m_pc);
    s.lenv = 8'(m_len);
    sb_q.push_back(s);
  endtask

  task automatic compare_snap(input string tag);
    snap_t s;
    check({tag, "_sb_depth"}, sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      for (int r = 0; r < 4; r++) begin
        sel = 2'(r);
        #1;
        check($sformatf("%s_reg%0d", tag, r), reg_val, s.regs[r*8 +: 8]);
      end
      check({tag, "_pc"}, pc, s.pcv);
      check({tag, "_len"}, len, s.lenv);
    end
  endtask

  task automatic check_reg(input string tag, input int idx, input logic [7:0] exp);
    sel = 2'(idx);
    #1;
    check(tag, reg_val, exp);
  endtask

  task automatic press(input logic l, input logic s, input logic r);
    btn_load = l;
    btn_step = s;
    btn_run  = r;
    repeat (10) @(negedge clk);
    btn_load = 1'b0;
    btn_step = 1'b0;
    btn_run  = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic m_load(input logic [7:0] b);
    if (m_len < DEPTH) begin
      m_mem[m_len] = b;
      m_len++;
    end
  endtask

  task automatic m_step();
    if (m_pc < m_len) begin
      m_exec(m_mem[m_pc]);
      m_pc = (m_pc + 1) % DEPTH;
    end else begin
      m_pc = 0;
    end
  endtask

  task automatic load_byte(input logic [7:0] b);
    instr_in = b;
    press(1'b1, 1'b0, 1'b0);
    m_load(b);
    push_snap();
    compare_snap($sformatf("load_%02h", b));
  endtask

  task automatic do_step(input string tag);
    press(1'b0, 1'b1, 1'b0);
    m_step();
    push_snap();
    compare_snap(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_reset();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int executed;
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_pc", pc, 0);
    check("rst_len", len, 0);
    check("rst_full", full, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 4; r++) check_reg($sformatf("rst_reg%0d", r), r, 8'h00);

    // Debounce: short glitches are rejected, a held press loads once.
    instr_in = 8'h18;
    repeat (3) begin
      btn_load = 1'b1;
      repeat (3) @(negedge clk);
      btn_load = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    check("db_glitch_len", len, 0);
    btn_load = 1'b1;
    repeat (10) @(negedge clk);
    check("db_hold_len", len, 1);
    btn_load = 1'b0;
    repeat (10) @(negedge clk);
    check("db_release_len", len, 1);
    m_load(8'h18);

    load_byte(8'h65);
    load_byte(8'h86);
    load_byte(8'hD3);

    // Single stepping
    for (int i = 0; i < 4; i++) do_step($sformatf("step%0d", i));
    check_reg("step_const_r0", 0, 8'h06);
    check_reg("step_const_r1", 1, 8'h90);
    check_reg("step_const_r2", 2, 8'h96);
    check_reg("step_const_r3", 3, 8'h76);
    check("step_const_pc", pc, 4);
    do_step("step_rewind");
    check("rewind_pc", pc, 0);

    // Coincident step and load: step wins, nothing appended.
    instr_in = 8'hFF;
    press(1'b1, 1'b1, 1'b0);
    m_step();
    push_snap();
    compare_snap("step_vs_load");

    // Run of the same program after reset
    do_reset();
    load_byte(8'h18);
    load_byte(8'h65);
    load_byte(8'h86);
    load_byte(8'hD3);
    busy_cnt = 0;
    press(1'b0, 1'b0, 1'b1);
    while (m_pc < m_len) begin
      m_exec(m_mem[m_pc]);
      m_pc++;
    end
    m_pc = 0;
    check("run_busy_cycles", busy_cnt, 4);
    check("run_busy_low", busy, 0);
    push_snap();
    compare_snap("run");
    check_reg("run_const_r3", 3, 8'h76);

    // Fill memory: reg0 = 1, then 15 accumulators reg2 += reg0.
    do_reset();
    load_byte(8'h04);
    for (int i = 0; i < 15; i++) load_byte(8'h8A);
    check("full_set", full, 1);
    check("full_len", len, 16);
    load_byte(8'hFF);
    check("full_17th_full", full, 1);

    // Abort mid-run with a second run press.
    busy_cnt = 0;
    btn_run = 1'b1;
    for (int i = 0; i < 30 && !busy; i++) @(negedge clk);
    check("abort_busy_rise", busy, 1);
    btn_run = 1'b0;
    repeat (7) @(negedge clk);
    btn_run = 1'b1;
    for (int i = 0; i < 30 && busy; i++) @(negedge clk);
    check("abort_busy_fall", busy, 0);
    btn_run = 1'b0;
    repeat (10) @(negedge clk);
    executed = busy_cnt - 1;
    check("abort_early", (executed > 0 && executed < 16), 1);
    for (int i = 0; i < executed && i < 16; i++) begin
      m_exec(m_mem[m_pc]);
      m_pc++;
    end
    push_snap();
    compare_snap("abort");
    check_reg("abort_reg2_sum", 2, 8'(executed - 1));

    // Reset while running
    btn_run = 1'b1;
    for (int i = 0; i < 30 && !busy; i++) @(negedge clk);
    check("midrun_busy", busy, 1);
    rst_n = 1'b0;
    btn_run = 1'b0;
    #1;
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_pc", pc, 0);
    check("midrun_rst_len", len, 0);
    check("midrun_rst_full", full, 0);
    for (int r = 0; r < 4; r++) check_reg($sformatf("midrun_rst_reg%0d", r), r, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
